// File: rtl/cla_seq_adder_ctrl.sv
// WIDTH-bit adder sequenced byte-by-byte over one shared 8-bit CLA slice.
// Define CLA_SEQ_SUB_EN to add the sub port (A-B via inverted B, carry-in 1).

module cla4_block (
  input  logic [3:0] g,
  input  logic [3:0] p,
  input  logic       ci,
  output logic [3:0] c,
  output logic       gg,
  output logic       pg
);
  always_comb begin
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & ci);
    gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]);
    pg   = &p;
  end
endmodule

module eb_adder_top (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] y,
  output logic       co
);
  logic [7:0] g;
  logic [7:0] p;
  logic [7:0] c;
  logic       gg_lo;
  logic       pg_lo;
  logic       gg_hi;
  logic       pg_hi;
  logic       c4;

  assign g = a & b;
  assign p = a ^ b;

  cla4_block u_lo (
    .g  (g[3:0]),
    .p  (p[3:0]),
    .ci (ci),
    .c  (c[3:0]),
    .gg (gg_lo),
    .pg (pg_lo)
  );

  // second-level lookahead: both group carries come straight from ci
  assign c4 = gg_lo | (pg_lo & ci);

  cla4_block u_hi (
    .g  (g[7:4]),
    .p  (p[7:4]),
    .ci (c4),
    .c  (c[7:4]),
    .gg (gg_hi),
    .pg (pg_hi)
  );

  assign co = gg_hi | (pg_hi & gg_lo) | (pg_hi & pg_lo & ci);
  assign y  = p ^ c;
endmodule

module cla_seq_adder_ctrl #(
  parameter  int WIDTH  = 32,
  localparam int NBYTES = WIDTH / 8,
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);
  generate
    if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_bad_width
      $error("cla_seq_adder_ctrl: WIDTH must be a multiple of 8 and >= 8");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           nxt;
  logic             live;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_q;
  logic             cout_q;
  logic             ovf_q;
  logic             carry;
  logic [CW-1:0]    idx;
  logic [7:0]       a_sl;
  logic [7:0]       b_sl;
  logic [7:0]       y;
  logic             co;
  logic             run;
  logic             accept;
  logic             last;
  logic             b_in_msb;

  assign accept = req_valid & req_ready;
  assign last   = (idx == CW'(NBYTES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (accept)    nxt = RUN;
      RUN:     if (last)      nxt = DONE;
      DONE:    if (res_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // live keeps req_ready low until the first edge after reset release
  always_comb begin
    req_ready = 1'b0;
    res_valid = 1'b0;
    run       = 1'b0;
    unique case (1'b1)
      (state == IDLE): req_ready = live;
      (state == RUN):  run       = 1'b1;
      (state == DONE): res_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx == CW'(i)) begin
        a_sl = a_reg[8*i +: 8];
        b_sl = b_reg[8*i +: 8];
      end
    end
  end

  eb_adder_top u_slice (
    .a  (a_sl),
    .b  (b_sl),
    .ci (carry),
    .y  (y),
    .co (co)
  );

  assign b_in_msb = b_reg[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live   <= 1'b0;
      a_reg  <= '0;
      b_reg  <= '0;
      res_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      carry  <= 1'b0;
      idx    <= '0;
    end else begin
      live <= 1'b1;
      if (accept) begin
        a_reg <= op_a;
        idx   <= '0;
`ifdef CLA_SEQ_SUB_EN
        b_reg <= sub ? ~op_b : op_b;
        carry <= sub | cin;
`else
        b_reg <= op_b;
        carry <= cin;
`endif
      end else if (run) begin
        carry <= co;
        for (int i = 0; i < NBYTES; i++) begin
          if (idx == CW'(i)) res_q[8*i +: 8] <= y;
        end
        if (last) begin
          cout_q <= co;
          ovf_q  <= (a_reg[WIDTH-1] == b_in_msb)
                 && (y[7] != a_reg[WIDTH-1]);
        end else begin
          idx <= idx + CW'(1);
        end
      end
    end
  end

  assign result = res_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;
endmodule
